// File: rtl/stream_cipher_pkg.sv
// ============================================================================
// Module   : stream_cipher_pkg
// Brief    : Shared types, default constants and the 8-step LFSR helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stream_cipher_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] c_DEFAULT_TAPS   = 32'h8020_0003;
    localparam int unsigned c_DEFAULT_WARMUP = 4;

    typedef struct packed {
        logic [31:0] next_state;
        logic [7:0]  ks;
    } lfsr_step_t;

    // Keystream byte comes from the pre-advance state; the state then takes
    // eight right-shift Galois steps.
    function automatic lfsr_step_t lfsr_step8(input logic [31:0] s, input logic [31:0] taps);
        lfsr_step_t res;
        logic [31:0] v;
        res.ks = s[7:0] ^ (s[15:8] & s[23:16]) ^ s[31:24];
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ taps) : (v >> 1);
        end
        res.next_state = v;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_cipher_if.sv
// ============================================================================
// Module   : stream_cipher_if
// Brief    : Key, input-stream and output-stream signals of stream_cipher.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stream_cipher_if;
    logic [31:0] key_i;
    logic        key_load_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        keyed_o;

    modport master (
        output key_i, key_load_i, data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, keyed_o
    );

    modport slave (
        input  key_i, key_load_i, data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, keyed_o
    );
endinterface

`default_nettype wire

// File: rtl/stream_cipher_keystream_gen.sv
// ============================================================================
// Module   : keystream_gen
// Brief    : Galois LFSR with zero-key substitution and filtered byte output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keystream_gen
    import stream_cipher_pkg::*;
#(
    parameter logic [31:0] TAPS = c_DEFAULT_TAPS
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic        i_advance,
    input  wire logic [31:0] i_key,
    output logic      [7:0]  o_ks
);

    logic [31:0] r_lfsr;
    lfsr_step_t  w_step;

    always_comb begin
        w_step = lfsr_step8(r_lfsr, TAPS);
    end

    assign o_ks = w_step.ks;

    // An all-zero state would never leave zero, so a zero key seeds with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 32'h0000_0001;
        end else if (i_load) begin
            r_lfsr <= (i_key == 32'h0) ? 32'h0000_0001 : i_key;
        end else if (i_advance) begin
            r_lfsr <= w_step.next_state;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_cipher.sv
// ============================================================================
// Module   : stream_cipher
// Brief    : Byte stream cipher: warm-up FSM, keystream XOR, 1-deep output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_cipher
    import stream_cipher_pkg::*;
#(
    parameter logic [31:0] TAPS   = c_DEFAULT_TAPS,
    parameter int unsigned WARMUP = c_DEFAULT_WARMUP
) (
    input  wire logic      clk,
    input  wire logic      rst,
    stream_cipher_if.slave bus
);

    localparam int unsigned             c_CNT_W    = (WARMUP > 2) ? $clog2(WARMUP) : 1;
    localparam logic [c_CNT_W-1:0]      c_CNT_LAST = c_CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         r_data;
    logic               r_valid;
    logic [7:0]         w_ks;
    logic               w_ready;
    logic               w_xfer;
    logic               w_advance;

    // Output slot frees up in the same cycle the downstream pops it.
    assign w_ready   = (r_state == S_RUN) && (!r_valid || bus.ready_i);
    assign w_xfer    = bus.valid_i && w_ready && !bus.key_load_i;
    assign w_advance = (r_state == S_WARM) || w_xfer;

    keystream_gen #(
        .TAPS (TAPS)
    ) u_keystream_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (bus.key_load_i),
        .i_advance (w_advance),
        .i_key     (bus.key_i),
        .o_ks      (w_ks)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bus.key_load_i) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (WARMUP == 0) ? S_RUN : S_WARM;
        end else begin
            case (r_state)
                S_WARM: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A key load discards any byte still waiting in the output slot.
    always_ff @(posedge clk) begin
        if (rst || bus.key_load_i) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= bus.data_i ^ w_ks;
            r_valid <= 1'b1;
        end else if (bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.keyed_o = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_stream_cipher.sv
// ============================================================================
// Module   : tb_stream_cipher
// Brief    : Randomised scoreboard bench for stream_cipher with a byte-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_cipher;

    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam int          WARMUP = 4;

    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 tb_clk = ~tb_clk;

    stream_cipher_if u_if();

    stream_cipher #(
        .TAPS   (TAPS),
        .WARMUP (WARMUP)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    // Reference model: keystream state plus the externally visible status.
    logic [31:0] m_s      = 32'h1;
    bit          m_loaded = 1'b0;
    int          m_wleft  = 0;
    bit          m_vld    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_advance(input logic [31:0] s);
        logic [31:0] v = s;
        for (int i = 0; i < 8; i++) begin
            if (v[0]) v = (v >> 1) ^ TAPS;
            else      v = v >> 1;
        end
        return v;
    endfunction

    function automatic logic [7:0] m_ks(input logic [31:0] s);
        return s[7:0] ^ (s[15:8] & s[23:16]) ^ s[31:24];
    endfunction

    // One clock of stimulus; called and returns at posedge+1.
    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit kl,
                         input logic [31:0] k, output bit xfer, output bit rdy);
        bit rr;
        bit exp_rdy;
        rr = kl ? 1'b0 : r;
        u_if.valid_i    = v;
        u_if.data_i     = d;
        u_if.ready_i    = rr;
        u_if.key_load_i = kl;
        u_if.key_i      = k;
        @(negedge tb_clk);
        exp_rdy = m_loaded && (m_wleft == 0) && (!m_vld || rr);
        check("keyed_o", u_if.keyed_o, m_loaded && (m_wleft == 0));
        check("ready_o", u_if.ready_o, exp_rdy);
        rdy  = u_if.ready_o;
        xfer = 1'b0;
        if (kl) begin
            m_s = (k == 32'h0) ? 32'h1 : k;
            for (int i = 0; i < WARMUP; i++) m_s = m_advance(m_s);
            m_loaded = 1'b1;
            m_wleft  = WARMUP;
            m_vld    = 1'b0;
            exp_q.delete();
        end else begin
            if (m_loaded && m_wleft > 0) begin
                m_wleft--;
            end else if (v && exp_rdy) begin
                exp_q.push_back(d ^ m_ks(m_s));
                m_s  = m_advance(m_s);
                xfer = 1'b1;
            end
            if (xfer)    m_vld = 1'b1;
            else if (rr) m_vld = 1'b0;
        end
        @(posedge tb_clk);
        #1;
    endtask

    task automatic load_key(input logic [31:0] k);
        bit x, rd;
        drive(1'b0, 8'h00, 1'b1, 1'b1, k, x, rd);
        for (int i = 0; i < WARMUP; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, x, rd);
    endtask

    task automatic drain();
        bit x, rd;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, x, rd);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, x, rd);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every downstream handshake.
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge tb_clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", u_if.valid_o, 1);
                check("hold_data", u_if.data_o, prev_data);
            end
            if (u_if.valid_o && u_if.ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_output: actual data_o=%02h required no output at %0t", u_if.data_o, $time);
                end else begin
                    check("data_o", u_if.data_o, exp_q.pop_front());
                end
                rx_q.push_back(u_if.data_o);
            end
            prev_hold = u_if.valid_o && !u_if.ready_i && !u_if.key_load_i;
            prev_data = u_if.data_o;
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         x, rd;
        int         cnt, total;
        logic [7:0] ct[16];
        logic [7:0] pt[8];
        logic [7:0] ref_q[$];
        logic [31:0] kb;

        u_if.key_i      = 32'h0;
        u_if.key_load_i = 1'b0;
        u_if.data_i     = 8'hA5;
        u_if.valid_i    = 1'b1;
        u_if.ready_i    = 1'b1;
        rst             = 1'b1;

        // Reset held two cycles with valid_i asserted
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        check("rst_data_o", u_if.data_o, 0);
        check("rst_valid_o", u_if.valid_o, 0);
        check("rst_ready_o", u_if.ready_o, 0);
        check("rst_keyed_o", u_if.keyed_o, 0);
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 32'h0, x, rd);
        drive(1'b1, 8'hC3, 1'b1, 1'b0, 32'h0, x, rd);

        // Key load and warm-up length
        drive(1'b0, 8'h00, 1'b1, 1'b1, 32'hDEAD_BEEF, x, rd);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, x, rd);
            if (rd) break;
            cnt++;
        end
        check("warmup_cycles", cnt, WARMUP);
        check("keyed_after_warmup", u_if.keyed_o, 1);

        // Round trip under 0x12345678
        load_key(32'h1234_5678);
        rx_q.delete();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 32'h0, x, rd);
        drain();
        check("rt_ct_count", rx_q.size(), 16);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            ct[i] = (i < rx_q.size()) ? rx_q[i] : 8'h00;
            if (ct[i] != 8'(i)) cnt++;
        end
        check("ct_differs_from_pt", (cnt != 0), 1);
        load_key(32'h1234_5678);
        rx_q.delete();
        for (int i = 0; i < 16; i++) drive(1'b1, ct[i], 1'b1, 1'b0, 32'h0, x, rd);
        drain();
        check("rt_pt_count", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) check("rt_plaintext", rx_q[i], i);

        // Zero key behaves as key 1
        for (int i = 0; i < 8; i++) pt[i] = 8'($urandom);
        load_key(32'h0);
        rx_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, pt[i], 1'b1, 1'b0, 32'h0, x, rd);
        drain();
        ref_q = rx_q;
        load_key(32'h1);
        rx_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, pt[i], 1'b1, 1'b0, 32'h0, x, rd);
        drain();
        check("zero_key_count", rx_q.size(), ref_q.size());
        for (int i = 0; i < 8 && i < rx_q.size() && i < ref_q.size(); i++)
            check("zero_key_stream", rx_q[i], ref_q[i]);

        // Backpressure: one byte accepted, then randomised ready/valid
        load_key($urandom);
        rx_q.delete();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0, 32'h0, x, rd);
            cnt += int'(x);
        end
        check("bp_accept_one", cnt, 1);
        total = cnt;
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 32'h0, x, rd);
            total += int'(x);
        end
        drain();
        check("bp_no_loss", rx_q.size(), total);

        // Reload mid-stream together with an input byte
        kb = $urandom;
        for (int i = 0; i < 8; i++) pt[i] = 8'($urandom);
        load_key($urandom);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 32'h0, x, rd);
        drive(1'b1, 8'h77, 1'b1, 1'b1, kb, x, rd);
        check("reload_valid_low", u_if.valid_o, 0);
        check("reload_keyed_low", u_if.keyed_o, 0);
        for (int i = 0; i < WARMUP; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, x, rd);
        rx_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, pt[i], 1'b1, 1'b0, 32'h0, x, rd);
        drain();
        ref_q = rx_q;
        load_key(kb);
        rx_q.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, pt[i], 1'b1, 1'b0, 32'h0, x, rd);
        drain();
        check("reload_count", ref_q.size(), rx_q.size());
        for (int i = 0; i < 8 && i < rx_q.size() && i < ref_q.size(); i++)
            check("reload_fresh_stream", ref_q[i], rx_q[i]);

        // Random traffic with occasional reloads
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 49) == 0), $urandom, x, rd);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_cipher.md
# stream_cipher

Byte-oriented synchronous stream cipher for the top-level user project. A 32-bit key seeds a Galois LFSR keystream generator with a nonlinear output filter. Each accepted plaintext byte is XORed with one keystream byte and emitted on a registered output stream. Encryption and decryption are the same operation.

## Interface
Parameters:
- `TAPS`, default 32'h8020_0003: Galois LFSR feedback mask.
- `WARMUP`, default 4: number of discarded keystream bytes after a key load.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `key_i`  in  32  key value; sampled when `key_load_i`=1.
- `key_load_i`  in  1  load key and restart warm-up.
- `data_i`  in  8  input byte (plaintext or ciphertext).
- `valid_i`  in  1  input byte valid.
- `ready_o`  out  1  block can accept an input byte this cycle.
- `data_o`  out  8  output byte, equal to `data_i` XOR keystream.
- `valid_o`  out  1  `data_o` valid.
- `ready_i`  in  1  downstream accepts `data_o`.
- `keyed_o`  out  1  high when the state is RUN (warm-up finished).

## Operation
- **State machine:** IDLE → WARM → RUN.
  - IDLE (after reset): no key loaded, `ready_o`=0.
  - `key_load_i` in any state: LFSR ← `key_i`, or 32'h0000_0001 if `key_i`==0 (avoids lock-up); warm-up counter ← 0; go to WARM; output register cleared (`valid_o`←0).
  - WARM: each cycle the LFSR advances 8 steps and the keystream is discarded. After `WARMUP` cycles, go to RUN.
  - RUN: LFSR advances 8 steps only on an input transfer (`valid_i` && `ready_o`).
- **LFSR step (right-shift Galois):** `lsb` = s[0]; s ← s>>1; if `lsb`, s ← s XOR `TAPS`. Eight steps are unrolled combinationally per cycle.
- **Keystream byte:** computed from the current state s, before advancing: ks = s[7:0] ^ (s[15:8] & s[23:16]) ^ s[31:24].
- **Output:** on transfer, `data_o` ← `data_i` ^ ks and `valid_o` ← 1. `valid_o` clears when `ready_i`=1 and no new transfer occurs in that cycle.
- **Ready:** `ready_o` = (state==RUN) && (!`valid_o` || `ready_i`). This is a 1-deep output buffer with pass-through throughput.
- **Simultaneous events:**
  - `key_load_i` beats an input transfer: the byte is dropped and the LFSR is reloaded.
  - `rst` beats everything.
  - Transfers in the same cycle as a downstream pop are both honoured.
- **Output stability:** while `valid_o`=1 and `ready_i`=0, `data_o` and `valid_o` hold stable.

## Timing
- **Reset values:** state=IDLE, LFSR=32'h0000_0001, `data_o`=0, `valid_o`=0, `ready_o`=0, `keyed_o`=0.
- **Key load:** `key_load_i` at edge N → `keyed_o`=1 and `ready_o` may assert after edge N+`WARMUP`.
- **Latency:** 1 cycle from input transfer to `valid_o`.
- **Throughput:** 1 byte per cycle while `ready_i`=1.
- **Reset or reload mid-stream:** the pending output byte is discarded and not presented.

## Structure
- Package `stream_cipher_pkg`: state enum {IDLE, WARM, RUN}, default `TAPS` constant, and a function `lfsr_step8` returning the next state plus keystream byte.
- One sub-module, `keystream_gen`: LFSR register, zero-key substitution, 8-step advance and filter. It takes `load`/`advance` inputs and produces a `ks` output.
- The top level holds the FSM, warm-up counter, XOR and output register.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0, `keyed_o`=0, `ready_o`=0; `valid_i`=1 ignored.
- **Key load and warm-up:** load key 32'hDEAD_BEEF → `ready_o`=0 for exactly 4 cycles, then `keyed_o`=1 and `ready_o`=1.
- **Round trip:** load key 32'h1234_5678 and encrypt bytes 0x00..0x0F. Reload the same key and feed the ciphertext → the output is 0x00..0x0F in order. Ciphertext is not equal to plaintext for at least one byte.
- **Zero key:** a stream under key 0 is identical to a stream under key 32'h0000_0001.
- **Backpressure:** hold `ready_i`=0 with `valid_i`=1 → exactly one byte is accepted, `ready_o` drops and `data_o` holds. Release `ready_i` → no byte is lost or duplicated versus a reference XOR model.
- **Reload mid-stream:** assert `key_load_i` together with `valid_i` → that byte is dropped, `valid_o`=0 next cycle, and the warm-up restarts. The subsequent stream equals a fresh-key stream.
